// File: rtl/pid_dac_pkg.sv
// Shared definitions for the DAC serial writer: FSM state encoding and small
// helpers used when sizing counters and formatting DAC words.
package pid_dac_pkg;

  // Frame sequencer states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Saturation limit of the 8-bit overrun counter.
  localparam logic [7:0] OVR_COUNT_MAX = 8'hFF;

  // Largest of three timing parameters; sizes the shared intrastate counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Two's complement to offset binary conversion only touches the sign bit.
  function automatic logic map_msb(input logic msb, input logic offset_bin);
    return msb ^ offset_bin;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator for the DAC serial clock. Counts modulo CLK_DIV
// while enabled and restarts from zero whenever it is disabled, so every
// entry into the shift state begins with a full SCLK-low half period.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: wraps after CLK_DIV enabled cycles, held at zero otherwise.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dac_serial_writer.sv
// Serial DAC writer: captures each valid preprocessor word and shifts it
// MSB-first over SCLK/DIN/CS_N with programmable chip-select setup, hold and
// inter-frame gap. A single newest-wins pending buffer absorbs words that
// arrive while a frame is in flight; words lost from it are counted.
module dac_serial_writer
  import pid_dac_pkg::*;
#(
  parameter int W_DATA     = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1,
  parameter int CS_GAP     = 2,
  parameter int OFFSET_BIN = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic              data_valid_in,
  output logic              dac_sclk_out,
  output logic              dac_din_out,
  output logic              dac_cs_n_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              overrun_out,
  output logic [7:0]        overrun_count_out
);

  // One SCLK edge per tick: two ticks per bit.
  localparam int EDGES   = 2 * W_DATA;
  localparam int EDGE_W  = $clog2(EDGES + 1);
  localparam int PHASE_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

  state_t              state;
  logic [W_DATA-1:0]   shift_q;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [W_DATA-1:0]   pend_data;
  logic                pend_valid;
  logic                tick;
  logic                phase_done;
  logic                gap_exit;
  logic                launch;
  logic                accept_pend;
  logic [W_DATA-1:0]   next_word;

  // Word as it goes on the wire, with the optional sign-bit flip.
  function automatic logic [W_DATA-1:0] dac_word(input logic [W_DATA-1:0] w);
    return {map_msb(w[W_DATA-1], OFFSET_BIN != 0), w[W_DATA-2:0]};
  endfunction

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en       (state == ST_SHIFT),
    .tick     (tick)
  );

  // Last cycle of the current timed state (setup, hold or gap).
  // NOTE: assigning a default before the case keeps this purely combinational;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_SETUP: phase_done = (phase_cnt == PHASE_W'(CS_SETUP - 1));
      ST_HOLD:  phase_done = (phase_cnt == PHASE_W'(CS_HOLD - 1));
      ST_GAP:   phase_done = (phase_cnt == PHASE_W'(CS_GAP - 1));
      default:  phase_done = 1'b0;
    endcase
  end

  // A strobe on the final gap cycle is the newest word and launches directly;
  // otherwise a held pending word launches. The same mux serves ST_IDLE,
  // where data_valid_in is the only reason to load.
  assign gap_exit    = (state == ST_GAP) && phase_done;
  assign launch      = gap_exit && (data_valid_in || pend_valid);
  assign accept_pend = data_valid_in && (state != ST_IDLE);
  assign next_word   = dac_word(data_valid_in ? data_in : pend_data);

  // Pending buffer and overrun accounting: newest word wins, a lost word pulses
  // overrun and bumps the saturating counter.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pend_data         <= '0;
      pend_valid        <= 1'b0;
      overrun_out       <= 1'b0;
      overrun_count_out <= '0;
    end else begin
      overrun_out <= accept_pend && pend_valid;
      if (accept_pend && pend_valid && (overrun_count_out != OVR_COUNT_MAX)) begin
        overrun_count_out <= overrun_count_out + 8'd1;
      end
      if (gap_exit) begin
        pend_valid <= 1'b0;
      end else if (accept_pend) begin
        pend_valid <= 1'b1;
        pend_data  <= data_in;
      end
    end
  end

  // Frame sequencer with registered SCLK/DIN/CS_N/busy/done.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= ST_IDLE;
      shift_q      <= '0;
      edge_cnt     <= '0;
      phase_cnt    <= '0;
      dac_sclk_out <= 1'b0;
      dac_din_out  <= 1'b0;
      dac_cs_n_out <= 1'b1;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (data_valid_in) begin
            shift_q      <= next_word;
            dac_din_out  <= next_word[W_DATA-1];
            dac_cs_n_out <= 1'b0;
            dac_sclk_out <= 1'b0;
            busy_out     <= 1'b1;
            phase_cnt    <= '0;
            state        <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_done) begin
            edge_cnt <= '0;
            state    <= ST_SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == EDGE_W'(EDGES - 1)) begin
              // Final falling edge: SCLK parks low, DIN keeps the last bit.
              dac_sclk_out <= 1'b0;
              phase_cnt    <= '0;
              state        <= ST_HOLD;
            end else if (!dac_sclk_out) begin
              dac_sclk_out <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit, giving a full
              // CLK_DIV of setup before the next rising edge.
              dac_sclk_out <= 1'b0;
              shift_q      <= shift_q << 1;
              dac_din_out  <= shift_q[W_DATA-2];
            end
          end
        end

        ST_HOLD: begin
          if (phase_done) begin
            dac_cs_n_out <= 1'b1;
            dac_din_out  <= 1'b0;
            done_out     <= 1'b1;
            phase_cnt    <= '0;
            state        <= ST_GAP;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (launch) begin
            shift_q      <= next_word;
            dac_din_out  <= next_word[W_DATA-1];
            dac_cs_n_out <= 1'b0;
            phase_cnt    <= '0;
            state        <= ST_SETUP;
          end else if (gap_exit) begin
            busy_out <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          dac_sclk_out <= 1'b0;
          dac_din_out  <= 1'b0;
          dac_cs_n_out <= 1'b1;
          busy_out     <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_writer.sv
// Testbench for dac_serial_writer: a frame-timeline model predicts every
// output on every cycle, and directed scenarios pin frame length, bit
// order, pending/overrun behaviour, gap-edge launch and async reset.
module tb_dac_serial_writer;

  localparam int W  = 16;
  localparam int CD = 2;
  localparam int SU = 1;
  localparam int HO = 1;
  localparam int GP = 2;
  localparam int SL = 2 * CD * W;
  localparam int FL = SU + SL + HO;

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          len;
    int          fall_cyc;
    int          rise_cyc;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        dv;
  logic        sclk, din, cs_n, busy, done, ovr;
  logic [7:0]  cnt_o;

  logic [15:0] ob_data;
  logic        ob_dv;
  logic        ob_sclk, ob_din, ob_cs_n, ob_busy, ob_done, ob_ovr;
  logic [7:0]  ob_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          cyc      = 0;
  int          m_fstart = -1000000;
  logic [15:0] m_fword  = '0;
  bit          m_pv     = 1'b0;
  logic [15:0] m_pw     = '0;
  int          m_cnt    = 0;
  bit          m_ovr    = 1'b0;

  // monitor bookkeeping
  frame_t frames[$];
  frame_t ob_frames[$];
  frame_t cur, ob_cur;
  bit     prev_cs = 1'b1, prev_sclk = 1'b0;
  bit     ob_prev_cs = 1'b1, ob_prev_sclk = 1'b0;
  int     done_total = 0, busy_total = 0, ovr_total = 0;

  dac_serial_writer #(
    .W_DATA(W), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP), .OFFSET_BIN(0)
  ) dut (
    .clk_in(clk), .reset_in(rst), .data_in(data), .data_valid_in(dv),
    .dac_sclk_out(sclk), .dac_din_out(din), .dac_cs_n_out(cs_n),
    .busy_out(busy), .done_out(done), .overrun_out(ovr), .overrun_count_out(cnt_o)
  );

  dac_serial_writer #(
    .W_DATA(W), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP), .OFFSET_BIN(1)
  ) dut_ob (
    .clk_in(clk), .reset_in(rst), .data_in(ob_data), .data_valid_in(ob_dv),
    .dac_sclk_out(ob_sclk), .dac_din_out(ob_din), .dac_cs_n_out(ob_cs_n),
    .busy_out(ob_busy), .done_out(ob_done), .overrun_out(ob_ovr), .overrun_count_out(ob_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: frames are described by their start cycle and word; the pending
  // slot and counter follow the newest-wins rules.
  always @(posedge clk) begin
    int  t;
    bit  in_frame;
    if (rst) begin
      m_fstart = -1000000;
      m_pv     = 1'b0;
      m_cnt    = 0;
      m_ovr    = 1'b0;
    end else begin
      t        = cyc - m_fstart;
      in_frame = (t >= 0) && (t < FL + GP);
      m_ovr    = 1'b0;
      if (!in_frame) begin
        if (dv) begin
          m_fstart = cyc + 1;
          m_fword  = data;
        end
      end else begin
        if (dv) begin
          if (m_pv) begin
            m_ovr = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          m_pv = 1'b1;
          m_pw = data;
        end
        if ((t == FL + GP - 1) && m_pv) begin
          m_fstart = cyc + 1;
          m_fword  = m_pw;
          m_pv     = 1'b0;
        end
      end
    end
    cyc++;
  end

  // Compare process plus frame/bit capture on the falling clock edge.
  always @(negedge clk) begin
    int   t, st;
    logic e_cs, e_sclk, e_busy, e_done, e_din;
    bit   din_known;
    if (rst) begin
      check("reset cs_n", cs_n, 1);
      check("reset sclk", sclk, 0);
      check("reset din", din, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset overrun", ovr, 0);
      check("reset count", cnt_o, 0);
    end else begin
      t = cyc - m_fstart;
      e_cs = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_din = 1'b0;
      din_known = 1'b1;
      if (t >= 0 && t < FL) begin
        e_cs   = 1'b0;
        e_busy = 1'b1;
        st     = t - SU;
        if (st >= SL) begin
          din_known = 1'b0;
        end else begin
          e_din = m_fword[W - 1 - ((st < 0) ? 0 : st / (2 * CD))];
          if (st >= 0) e_sclk = ((st % (2 * CD)) >= CD);
        end
      end else if (t >= FL && t < FL + GP) begin
        e_busy = 1'b1;
        e_done = (t == FL);
      end
      check("cs_n", cs_n, e_cs);
      check("sclk", sclk, e_sclk);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      if (din_known) check("din", din, e_din);
      check("overrun", ovr, m_ovr);
      check("count", cnt_o, m_cnt);
      if (done) done_total++;
      if (busy) busy_total++;
      if (ovr)  ovr_total++;
    end

    if (prev_cs && !cs_n) begin
      cur.word = '0; cur.rises = 0; cur.len = 0; cur.fall_cyc = cyc; cur.rise_cyc = 0;
    end
    if (!cs_n) cur.len++;
    if (!prev_sclk && sclk) begin
      cur.word = {cur.word[14:0], din};
      cur.rises++;
    end
    if (!prev_cs && cs_n) begin
      cur.rise_cyc = cyc;
      frames.push_back(cur);
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;

    if (ob_prev_cs && !ob_cs_n) begin
      ob_cur.word = '0; ob_cur.rises = 0; ob_cur.len = 0; ob_cur.fall_cyc = cyc; ob_cur.rise_cyc = 0;
    end
    if (!ob_cs_n) ob_cur.len++;
    if (!ob_prev_sclk && ob_sclk) begin
      ob_cur.word = {ob_cur.word[14:0], ob_din};
      ob_cur.rises++;
    end
    if (!ob_prev_cs && ob_cs_n) begin
      ob_cur.rise_cyc = cyc;
      ob_frames.push_back(ob_cur);
    end
    ob_prev_cs   = ob_cs_n;
    ob_prev_sclk = ob_sclk;
  end

  task automatic strobe(input logic [15:0] w, input bit use_ob);
    @(negedge clk);
    if (use_ob) begin ob_data = w; ob_dv = 1'b1; end
    else begin data = w; dv = 1'b1; end
    @(negedge clk);
    ob_dv = 1'b0;
    dv    = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit use_ob);
    int n;
    n = 0;
    while (((use_ob ? ob_busy : busy) !== 1'b0) && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check(use_ob ? "ob idle reached" : "idle reached", use_ob ? ob_busy : busy, 0);
  endtask

  task automatic check_frame(input int idx, input logic [15:0] word, input string tag);
    if (frames.size() <= idx) begin
      check({tag, " frame present"}, frames.size(), idx + 1);
    end else begin
      check({tag, " bits"}, frames[idx].word, word);
      check({tag, " sclk rises"}, frames[idx].rises, 16);
      check({tag, " cs_n low cycles"}, frames[idx].len, 66);
    end
  endtask

  initial begin
    int nf, b0, d0, o0, c0, cs;
    rst = 1'b1; dv = 1'b0; data = '0; ob_dv = 1'b0; ob_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle cs_n after reset", cs_n, 1);
    check("idle busy after reset", busy, 0);

    // Offset binary: 0x8000 -> 0x0000, 0x7FFF -> 0xFFFF on the wire.
    strobe(16'h8000, 1'b1);
    wait_idle(200, 1'b1);
    strobe(16'h7FFF, 1'b1);
    wait_idle(200, 1'b1);
    check("ob frame count", ob_frames.size(), 2);
    if (ob_frames.size() >= 2) begin
      check("ob 0x8000 bits", ob_frames[0].word, 16'h0000);
      check("ob 0x7FFF bits", ob_frames[1].word, 16'hFFFF);
      check("ob cs_n low cycles", ob_frames[1].len, 66);
    end

    // Single frame 0xA5C3.
    nf = frames.size(); b0 = busy_total; d0 = done_total;
    strobe(16'hA5C3, 1'b0);
    wait_idle(200, 1'b0);
    check_frame(nf, 16'hA5C3, "single");
    check("single done pulses", done_total - d0, 1);
    check("single busy cycles", busy_total - b0, 68);
    check("single frames", frames.size(), nf + 1);

    // One word arriving mid-frame: second frame after exactly the gap.
    nf = frames.size(); o0 = ovr_total;
    strobe(16'h1111, 1'b0);
    repeat (20) @(negedge clk);
    strobe(16'h2222, 1'b0);
    wait_idle(400, 1'b0);
    check_frame(nf, 16'h1111, "pend first");
    check_frame(nf + 1, 16'h2222, "pend second");
    if (frames.size() >= nf + 2)
      check("pend gap cycles", frames[nf+1].fall_cyc - frames[nf].rise_cyc, 2);
    check("pend no overrun", ovr_total - o0, 0);
    check("pend count", cnt_o, 0);

    // Three words during one frame: newest wins, two overruns.
    nf = frames.size(); o0 = ovr_total;
    strobe(16'h1111, 1'b0);
    strobe(16'h2222, 1'b0);
    repeat (3) @(negedge clk);
    strobe(16'h3333, 1'b0);
    repeat (3) @(negedge clk);
    strobe(16'h4444, 1'b0);
    wait_idle(400, 1'b0);
    check_frame(nf, 16'h1111, "ovr first");
    check_frame(nf + 1, 16'h4444, "ovr second");
    check("ovr frames", frames.size(), nf + 2);
    check("ovr pulses", ovr_total - o0, 2);
    check("ovr count", cnt_o, 2);

    // Continuous strobes force the counter to saturate.
    @(negedge clk);
    dv = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data = 16'(i * 16'h0101);
      @(negedge clk);
    end
    dv = 1'b0;
    wait_idle(600, 1'b0);
    check("saturated count", cnt_o, 255);

    // Strobe on the final gap cycle launches the next frame at once.
    nf = frames.size();
    @(negedge clk);
    data = 16'h1234; dv = 1'b1; c0 = cyc;
    @(negedge clk);
    dv = 1'b0;
    repeat (67) @(negedge clk);
    check("last gap cycle cs_n high", cs_n, 1);
    data = 16'h5A5A; dv = 1'b1; cs = cyc;
    @(negedge clk);
    dv = 1'b0;
    wait_idle(400, 1'b0);
    check_frame(nf, 16'h1234, "edge first");
    check_frame(nf + 1, 16'h5A5A, "edge second");
    if (frames.size() >= nf + 2) begin
      check("edge fall next cycle", frames[nf+1].fall_cyc, cs + 1);
      check("edge gap cycles", frames[nf+1].fall_cyc - frames[nf].rise_cyc, 2);
      check("edge first start", frames[nf].fall_cyc, c0 + 1);
    end

    // Asynchronous reset at bit 7 with a word pending.
    strobe(16'hFFFF, 1'b0);
    strobe(16'h1357, 1'b0);
    repeat (27) @(negedge clk);
    check("pre-reset cs_n low", cs_n, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async cs_n", cs_n, 1);
    check("async sclk", sclk, 0);
    check("async din", din, 0);
    check("async busy", busy, 0);
    check("async count", cnt_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nf = frames.size();
    repeat (80) @(negedge clk);
    check("pending dropped by reset", frames.size(), nf);
    check("idle after reset", busy, 0);
    strobe(16'hC3A5, 1'b0);
    wait_idle(200, 1'b0);
    check_frame(nf, 16'hC3A5, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
